// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush-bubble insertion and a saturating count of discarded instructions.
module pipe_skid_stage #(
  parameter int unsigned              DATA_W      = 64,
  parameter int unsigned              CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]        BUBBLE_CTRL = '0,
  parameter bit                       SKID        = 1'b1,
  parameter int unsigned              CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  discard_cnt
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } stageState_e;

  stageState_e       state_q;
  logic [DATA_W-1:0] mainData_q;
  logic [CTRL_W-1:0] mainCtrl_q;
  logic              mainBubble_q;
  logic [DATA_W-1:0] skidData_q;
  logic [CTRL_W-1:0] skidCtrl_q;
  logic [CNT_W-1:0]  discardCnt_q;
  logic [CNT_W-1:0]  discardCnt_d;

  logic       inFire;
  logic       outFire;
  logic [1:0] discardNum;
  logic [CNT_W:0] cntSum;

  assign out_valid   = (state_q != EMPTY);
  assign out_data    = mainData_q;
  assign out_ctrl    = mainCtrl_q;
  assign out_bubble  = mainBubble_q;
  assign discard_cnt = discardCnt_q;

  // With the skid buffer, ready is a pure decode of registered state so the
  // upstream stage never sees a combinational path from out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !flush) begin
      if (SKID) in_ready = (state_q != SKIDFULL);
      else      in_ready = ~out_valid | out_ready;
    end
  end

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  // The skid entry only ever holds upstream data, so it is never a bubble.
  // A main entry leaving on the flush cycle counts as delivered.
  always_comb begin
    discardNum = 2'd0;
    if (flush) begin
      if (state_q != EMPTY && !mainBubble_q && !outFire) discardNum = discardNum + 2'd1;
      if (state_q == SKIDFULL)                           discardNum = discardNum + 2'd1;
    end
    cntSum       = {1'b0, discardCnt_q} + (CNT_W+1)'(discardNum);
    discardCnt_d = cntSum[CNT_W] ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      mainData_q   <= '0;
      mainCtrl_q   <= BUBBLE_CTRL;
      mainBubble_q <= 1'b0;
      skidData_q   <= '0;
      skidCtrl_q   <= BUBBLE_CTRL;
      discardCnt_q <= '0;
    end else begin
      discardCnt_q <= discardCnt_d;
      if (flush) begin
        state_q      <= FULL;
        mainData_q   <= '0;
        mainCtrl_q   <= BUBBLE_CTRL;
        mainBubble_q <= 1'b1;
        skidData_q   <= '0;
        skidCtrl_q   <= BUBBLE_CTRL;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (inFire) begin
              state_q      <= FULL;
              mainData_q   <= in_data;
              mainCtrl_q   <= in_ctrl;
              mainBubble_q <= 1'b0;
            end
          end
          FULL: begin
            if (outFire && inFire) begin
              mainData_q   <= in_data;
              mainCtrl_q   <= in_ctrl;
              mainBubble_q <= 1'b0;
            end else if (outFire) begin
              state_q <= EMPTY;
            end else if (inFire) begin
              state_q    <= SKIDFULL;
              skidData_q <= in_data;
              skidCtrl_q <= in_ctrl;
            end
          end
          SKIDFULL: begin
            if (outFire) begin
              state_q      <= FULL;
              mainData_q   <= skidData_q;
              mainCtrl_q   <= skidCtrl_q;
              mainBubble_q <= 1'b0;
              skidData_q   <= '0;
              skidCtrl_q   <= BUBBLE_CTRL;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a skid instance with a queue-driven monitor,
// a narrow-counter instance for saturation and a no-skid instance for backpressure.
module tb_pipe_skid_stage;

  localparam logic [3:0] BCTRL = 4'h5;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ctrl;
    logic       bubble;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       m_in_valid, m_in_ready, m_flush, m_out_valid, m_out_ready, m_out_bubble;
  logic [7:0] m_in_data, m_out_data, m_cnt;
  logic [3:0] m_in_ctrl, m_out_ctrl;

  logic       s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_out_bubble;
  logic [7:0] s_in_data, s_out_data;
  logic [3:0] s_out_ctrl;
  logic [1:0] s_cnt;

  logic       n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready, n_out_bubble;
  logic [7:0] n_in_data, n_out_data, n_cnt;
  logic [3:0] n_out_ctrl;

  int testsRun = 0;
  int failCount = 0;
  entry_t sbq[$];

  pipe_skid_stage #(.DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(BCTRL), .SKID(1'b1), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_ctrl(m_in_ctrl), .flush(m_flush), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_data(m_out_data), .out_ctrl(m_out_ctrl), .out_bubble(m_out_bubble), .discard_cnt(m_cnt));

  pipe_skid_stage #(.DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(BCTRL), .SKID(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_ctrl(4'h1), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_bubble(s_out_bubble), .discard_cnt(s_cnt));

  pipe_skid_stage #(.DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(BCTRL), .SKID(1'b0), .CNT_W(8)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .in_ctrl(4'h2), .flush(n_flush), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .out_ctrl(n_out_ctrl), .out_bubble(n_out_bubble), .discard_cnt(n_cnt));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  // Drives one upstream entry on the main instance for a single cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] c, input bit expectDelivery);
    m_in_valid = 1'b1;
    m_in_data  = d;
    m_in_ctrl  = c;
    atNeg();
    checkOutput("accept", {31'd0, m_in_ready}, 32'd1);
    if (expectDelivery) sbq.push_back('{data: d, ctrl: c, bubble: 1'b0});
    tick();
    m_in_valid = 1'b0;
  endtask

  // Monitor: every main-instance handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_out_valid && m_out_ready) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_out", {19'd0, m_out_data, m_out_ctrl, m_out_bubble}, 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = sbq.pop_front();
        checkOutput("sb_entry", {19'd0, m_out_data, m_out_ctrl, m_out_bubble},
                    {19'd0, e.data, e.ctrl, e.bubble});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] satExp [3];
    satExp = '{2'd2, 2'd3, 2'd3};
    rst = 1'b1;
    m_in_valid = 0; m_in_data = 0; m_in_ctrl = 0; m_flush = 0; m_out_ready = 0;
    s_in_valid = 0; s_in_data = 0; s_flush = 0; s_out_ready = 0;
    n_in_valid = 0; n_in_data = 0; n_flush = 0; n_out_ready = 0;
    tick(); tick();
    atNeg();
    checkOutput("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("rst_out_ctrl", {28'd0, m_out_ctrl}, {28'd0, BCTRL});
    checkOutput("rst_out_bubble", {31'd0, m_out_bubble}, 32'd0);
    checkOutput("rst_cnt", {24'd0, m_cnt}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, m_in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    atNeg();
    checkOutput("post_rst_in_ready", {31'd0, m_in_ready}, 32'd1);
    tick();

    // Streaming with out_ready high: one-cycle latency, ready never drops.
    m_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      m_in_valid = 1'b1; m_in_data = 8'(i); m_in_ctrl = 4'(i);
      atNeg();
      checkOutput("stream_ready", {31'd0, m_in_ready}, 32'd1);
      if (i > 1) checkOutput("stream_latency", {24'd0, m_out_data}, 32'(i - 1));
      sbq.push_back('{data: 8'(i), ctrl: 4'(i), bubble: 1'b0});
      tick();
    end
    m_in_valid = 1'b0;
    atNeg();
    tick();
    tick();

    // Stall into the skid buffer, then drain in order.
    m_out_ready = 1'b0;
    applyStimulus(8'hA1, 4'h1, 1'b1);
    applyStimulus(8'hB2, 4'h2, 1'b1);
    atNeg();
    checkOutput("skidfull_ready", {31'd0, m_in_ready}, 32'd0);
    checkOutput("stall_data", {24'd0, m_out_data}, 32'hA1);
    tick();
    atNeg();
    checkOutput("stall_data_stable", {24'd0, m_out_data}, 32'hA1);
    tick();
    m_out_ready = 1'b1;
    atNeg();
    tick();
    atNeg();
    checkOutput("ready_after_drain", {31'd0, m_in_ready}, 32'd1);
    tick();

    // Flush with two held entries; the concurrent input must be refused.
    m_out_ready = 1'b0;
    applyStimulus(8'hC3, 4'h3, 1'b0);
    applyStimulus(8'hD4, 4'h4, 1'b0);
    m_in_valid = 1'b1; m_in_data = 8'hEE; m_in_ctrl = 4'hE; m_flush = 1'b1;
    atNeg();
    checkOutput("flush_in_ready", {31'd0, m_in_ready}, 32'd0);
    tick();
    m_flush = 1'b0; m_in_valid = 1'b0;
    atNeg();
    checkOutput("flush_valid", {31'd0, m_out_valid}, 32'd1);
    checkOutput("flush_bubble", {31'd0, m_out_bubble}, 32'd1);
    checkOutput("flush_ctrl", {28'd0, m_out_ctrl}, {28'd0, BCTRL});
    checkOutput("flush_data", {24'd0, m_out_data}, 32'd0);
    checkOutput("flush_cnt", {24'd0, m_cnt}, 32'd2);
    sbq.push_back('{data: 8'h00, ctrl: BCTRL, bubble: 1'b1});
    tick();
    m_out_ready = 1'b1;
    atNeg();
    tick();

    // Flush from empty, then again while holding only a bubble: count unchanged.
    m_out_ready = 1'b0;
    m_flush = 1'b1;
    tick();
    tick();
    m_flush = 1'b0;
    atNeg();
    checkOutput("bubble_reflush_cnt", {24'd0, m_cnt}, 32'd2);
    checkOutput("bubble_reflush_flag", {31'd0, m_out_bubble}, 32'd1);
    sbq.push_back('{data: 8'h00, ctrl: BCTRL, bubble: 1'b1});
    tick();
    m_out_ready = 1'b1;
    atNeg();
    tick();

    // Entry leaving on the flush cycle is delivered, not discarded.
    applyStimulus(8'h5A, 4'h3, 1'b1);
    m_flush = 1'b1;
    atNeg();
    tick();
    m_flush = 1'b0;
    sbq.push_back('{data: 8'h00, ctrl: BCTRL, bubble: 1'b1});
    atNeg();
    checkOutput("fire_on_flush_cnt", {24'd0, m_cnt}, 32'd2);
    tick();

    // Reset in the middle of a full stall drops everything uncounted.
    m_out_ready = 1'b0;
    applyStimulus(8'h61, 4'h6, 1'b0);
    applyStimulus(8'h72, 4'h7, 1'b0);
    atNeg();
    checkOutput("pre_rst_skidfull", {31'd0, m_in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    atNeg();
    checkOutput("midrst_valid", {31'd0, m_out_valid}, 32'd0);
    checkOutput("midrst_ctrl", {28'd0, m_out_ctrl}, {28'd0, BCTRL});
    checkOutput("midrst_bubble", {31'd0, m_out_bubble}, 32'd0);
    checkOutput("midrst_cnt", {24'd0, m_cnt}, 32'd0);
    checkOutput("midrst_ready", {31'd0, m_in_ready}, 32'd1);
    tick();

    // Saturating 2-bit counter: each round discards two real entries.
    for (int r = 0; r < 3; r++) begin
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 8'(r + 1);
      tick();
      s_in_data = 8'(r + 17);
      tick();
      s_in_valid = 1'b0; s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      atNeg();
      checkOutput("sat_cnt", {30'd0, s_cnt}, {30'd0, satExp[r]});
      tick();
    end

    // Single-entry mode: ready follows out_ready combinationally.
    n_out_ready = 1'b0;
    n_in_valid = 1'b1; n_in_data = 8'h11;
    atNeg();
    checkOutput("ns_empty_ready", {31'd0, n_in_ready}, 32'd1);
    tick();
    n_in_data = 8'h22;
    atNeg();
    checkOutput("ns_stall_ready", {31'd0, n_in_ready}, 32'd0);
    checkOutput("ns_stall_data", {24'd0, n_out_data}, 32'h11);
    tick();
    atNeg();
    checkOutput("ns_hold_data", {24'd0, n_out_data}, 32'h11);
    tick();
    n_out_ready = 1'b1;
    atNeg();
    checkOutput("ns_pass_ready", {31'd0, n_in_ready}, 32'd1);
    tick();
    n_in_valid = 1'b0;
    atNeg();
    checkOutput("ns_replace_data", {24'd0, n_out_data}, 32'h22);
    checkOutput("ns_replace_valid", {31'd0, n_out_valid}, 32'd1);
    checkOutput("ns_bubble", {31'd0, n_out_bubble}, 32'd0);
    tick();

    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
